// File: rtl/input_mapper.sv
// input_mapper: player-input front end between hps_io and the game core.
// Decodes PS/2 make/break events into per-key state for players 0 and 1,
// merges them with the joystick words, then applies opposing-direction
// cleaning, per-player autofire on button 0, coin pulse shaping and an
// inhibit gate. Every output is registered.
module input_mapper #(
  parameter int PLAYERS      = 2,
  parameter int BUTTONS      = 2,
  parameter int SOCD_NEUTRAL = 1,
  parameter int COIN_CYCLES  = 96000,
  parameter int AUTOFIRE_DIV = 800000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [10:0]                      ps2_key,
  input  logic [PLAYERS*(6+BUTTONS)-1:0]   joystick,
  input  logic [PLAYERS-1:0]               autofire_en,
  input  logic                             inhibit,
  output logic [4*PLAYERS-1:0]             dir,
  output logic [BUTTONS*PLAYERS-1:0]       buttons,
  output logic [PLAYERS-1:0]               start,
  output logic [PLAYERS-1:0]               coin
);

  localparam int JOY_W  = 6 + BUTTONS;
  localparam int KEY_W  = 2 * JOY_W;
  localparam int POS_W  = $clog2(KEY_W);
  localparam int COIN_W = $clog2(COIN_CYCLES + 1);
  localparam int AF_W   = $clog2(AUTOFIRE_DIV + 1);

  typedef enum logic {AF_IDLE,   AF_FIRE}    af_state_t;
  typedef enum logic {COIN_IDLE, COIN_PULSE} coin_state_t;

  // Bit position of a key inside the keyboard state (players 0 and 1,
  // laid out exactly like two joystick words).
  function automatic logic [POS_W-1:0] key_pos(input int pl, input int bit_idx);
    return POS_W'(pl * JOY_W + bit_idx);
  endfunction

  logic             r_old_toggle;
  logic             r_primed;
  logic [KEY_W-1:0] r_key;
  logic             w_event;
  logic             w_key_hit;
  logic [POS_W-1:0] w_key_pos;
  logic             w_unused;

  // The extended-code flag carries no meaning for this key map.
  assign w_unused = ps2_key[8];

  // A toggle change is one event, but only once the toggle has been
  // captured after reset, so a stale toggle level is never decoded.
  assign w_event = r_primed && (ps2_key[10] != r_old_toggle);

  // Scan code to keyboard-state bit; unlisted codes and buttons beyond
  // BUTTONS produce no hit.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_key_hit = 1'b0;
    w_key_pos = '0;
    case (ps2_key[7:0])
      8'h74: begin w_key_hit = 1'b1;         w_key_pos = key_pos(0, 0);           end
      8'h6B: begin w_key_hit = 1'b1;         w_key_pos = key_pos(0, 1);           end
      8'h72: begin w_key_hit = 1'b1;         w_key_pos = key_pos(0, 2);           end
      8'h75: begin w_key_hit = 1'b1;         w_key_pos = key_pos(0, 3);           end
      8'h14: begin w_key_hit = 1'b1;         w_key_pos = key_pos(0, 4);           end
      8'h11: begin w_key_hit = (BUTTONS > 1); w_key_pos = key_pos(0, 5);          end
      8'h29: begin w_key_hit = (BUTTONS > 2); w_key_pos = key_pos(0, 6);          end
      8'h12: begin w_key_hit = (BUTTONS > 3); w_key_pos = key_pos(0, 7);          end
      8'h16: begin w_key_hit = 1'b1;         w_key_pos = key_pos(0, 4 + BUTTONS); end
      8'h2E: begin w_key_hit = 1'b1;         w_key_pos = key_pos(0, 5 + BUTTONS); end
      8'h34: begin w_key_hit = 1'b1;         w_key_pos = key_pos(1, 0);           end
      8'h23: begin w_key_hit = 1'b1;         w_key_pos = key_pos(1, 1);           end
      8'h2B: begin w_key_hit = 1'b1;         w_key_pos = key_pos(1, 2);           end
      8'h2D: begin w_key_hit = 1'b1;         w_key_pos = key_pos(1, 3);           end
      8'h1C: begin w_key_hit = 1'b1;         w_key_pos = key_pos(1, 4);           end
      8'h1B: begin w_key_hit = (BUTTONS > 1); w_key_pos = key_pos(1, 5);          end
      8'h15: begin w_key_hit = (BUTTONS > 2); w_key_pos = key_pos(1, 6);          end
      8'h1D: begin w_key_hit = (BUTTONS > 3); w_key_pos = key_pos(1, 7);          end
      8'h1E: begin w_key_hit = 1'b1;         w_key_pos = key_pos(1, 4 + BUTTONS); end
      8'h36: begin w_key_hit = 1'b1;         w_key_pos = key_pos(1, 5 + BUTTONS); end
      default: ;
    endcase
  end

  // Toggle tracker: follows ps2_key[10] every cycle, inhibit included.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_old_toggle <= 1'b0;
      r_primed     <= 1'b0;
    end else begin
      r_old_toggle <= ps2_key[10];
      r_primed     <= 1'b1;
    end
  end

  // Keyboard key state; inhibit wipes it and discards incoming events.
  // NOTE: the key state is a handful of flops, not a RAM, so it is reset like any other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key <= '0;
    end else if (inhibit) begin
      r_key <= '0;
    end else if (w_event && w_key_hit) begin
      r_key[w_key_pos] <= ps2_key[9];
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [JOY_W-1:0]   w_raw;
    logic [1:0]         w_lr;
    logic [1:0]         w_ud;
    logic [BUTTONS-1:0] w_btn_out;

    af_state_t          r_af_state,   w_af_state_nxt;
    logic               r_af_phase,   w_af_phase_nxt;
    logic [AF_W-1:0]    r_af_cnt,     w_af_cnt_nxt;
    logic               r_btn0_prev;

    coin_state_t        r_coin_state, w_coin_state_nxt;
    logic [COIN_W-1:0]  r_coin_cnt,   w_coin_cnt_nxt;
    logic               r_coin_prev;

    logic [3:0]         r_dir;
    logic [BUTTONS-1:0] r_btn;
    logic               r_start;
    logic               r_coin;

    if (p < 2) begin : g_kbd
      assign w_raw = joystick[p*JOY_W +: JOY_W] | r_key[p*JOY_W +: JOY_W];
    end else begin : g_joy
      assign w_raw = joystick[p*JOY_W +: JOY_W];
    end

    // Opposing directions cancel to neutral when cleaning is enabled.
    assign w_lr = (SOCD_NEUTRAL != 0 && (&w_raw[1:0])) ? 2'b00 : w_raw[1:0];
    assign w_ud = (SOCD_NEUTRAL != 0 && (&w_raw[3:2])) ? 2'b00 : w_raw[3:2];

    // Autofire next state: start firing on a btn0 rising edge, square
    // wave of AUTOFIRE_DIV cycles per half-period, stop on release.
    always_comb begin
      w_af_state_nxt = r_af_state;
      w_af_phase_nxt = r_af_phase;
      w_af_cnt_nxt   = r_af_cnt;
      if (inhibit || !autofire_en[p]) begin
        w_af_state_nxt = AF_IDLE;
        w_af_phase_nxt = 1'b0;
        w_af_cnt_nxt   = '0;
      end else begin
        case (r_af_state)
          AF_IDLE: begin
            if (w_raw[4] && !r_btn0_prev) begin
              w_af_state_nxt = AF_FIRE;
              w_af_phase_nxt = 1'b1;
              w_af_cnt_nxt   = '0;
            end
          end
          AF_FIRE: begin
            if (!w_raw[4]) begin
              w_af_state_nxt = AF_IDLE;
              w_af_phase_nxt = 1'b0;
              w_af_cnt_nxt   = '0;
            end else if (r_af_cnt == AF_W'(AUTOFIRE_DIV - 1)) begin
              w_af_cnt_nxt   = '0;
              w_af_phase_nxt = ~r_af_phase;
            end else begin
              w_af_cnt_nxt   = r_af_cnt + AF_W'(1);
            end
          end
          default: w_af_state_nxt = AF_IDLE;
        endcase
      end
    end

    // Coin next state: one COIN_CYCLES pulse per rising edge, edges
    // during a pulse ignored.
    always_comb begin
      w_coin_state_nxt = r_coin_state;
      w_coin_cnt_nxt   = r_coin_cnt;
      if (inhibit) begin
        w_coin_state_nxt = COIN_IDLE;
        w_coin_cnt_nxt   = '0;
      end else begin
        case (r_coin_state)
          COIN_IDLE: begin
            if (w_raw[5+BUTTONS] && !r_coin_prev) begin
              w_coin_state_nxt = COIN_PULSE;
              w_coin_cnt_nxt   = COIN_W'(COIN_CYCLES - 1);
            end
          end
          COIN_PULSE: begin
            if (r_coin_cnt == '0) begin
              w_coin_state_nxt = COIN_IDLE;
            end else begin
              w_coin_cnt_nxt   = r_coin_cnt - COIN_W'(1);
            end
          end
          default: w_coin_state_nxt = COIN_IDLE;
        endcase
      end
    end

    // Button word: btn0 replaced by the autofire phase when enabled.
    always_comb begin
      w_btn_out = w_raw[4 +: BUTTONS];
      if (autofire_en[p]) begin
        w_btn_out[0] = w_af_phase_nxt;
      end
    end

    // FSM registers. Edge-detect history is cleared under inhibit (and
    // under a disabled autofire) so an input still held afterwards is
    // seen as a fresh press.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_af_state   <= AF_IDLE;
        r_af_phase   <= 1'b0;
        r_af_cnt     <= '0;
        r_btn0_prev  <= 1'b0;
        r_coin_state <= COIN_IDLE;
        r_coin_cnt   <= '0;
        r_coin_prev  <= 1'b0;
      end else begin
        r_af_state   <= w_af_state_nxt;
        r_af_phase   <= w_af_phase_nxt;
        r_af_cnt     <= w_af_cnt_nxt;
        r_btn0_prev  <= (inhibit || !autofire_en[p]) ? 1'b0 : w_raw[4];
        r_coin_state <= w_coin_state_nxt;
        r_coin_cnt   <= w_coin_cnt_nxt;
        r_coin_prev  <= inhibit ? 1'b0 : w_raw[5+BUTTONS];
      end
    end

    // Output register; inhibit forces everything low.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_dir   <= '0;
        r_btn   <= '0;
        r_start <= 1'b0;
        r_coin  <= 1'b0;
      end else if (inhibit) begin
        r_dir   <= '0;
        r_btn   <= '0;
        r_start <= 1'b0;
        r_coin  <= 1'b0;
      end else begin
        r_dir   <= {w_ud, w_lr};
        r_btn   <= w_btn_out;
        r_start <= w_raw[4+BUTTONS];
        r_coin  <= (w_coin_state_nxt == COIN_PULSE);
      end
    end

    assign dir[4*p +: 4]             = r_dir;
    assign buttons[p*BUTTONS +: BUTTONS] = r_btn;
    assign start[p]                  = r_start;
    assign coin[p]                   = r_coin;
  end

endmodule

// File: tb/tb_input_mapper.sv
// Scoreboard bench for input_mapper: the driver pushes cycle-tagged
// expected values, a negedge monitor pops and compares them.
module tb_input_mapper;

  localparam int PLAYERS = 2;
  localparam int BUTTONS = 2;
  localparam int JOY_W   = 6 + BUTTONS;

  localparam int S_DIR   = 0;
  localparam int S_BTN   = 1;
  localparam int S_START = 2;
  localparam int S_COIN  = 3;
  localparam int S_DIR_B = 4;

  typedef struct {
    int          cyc;
    string       name;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic                       clk;
  logic                       reset;
  logic [10:0]                ps2_key;
  logic [PLAYERS*JOY_W-1:0]   joystick;
  logic [PLAYERS-1:0]         autofire_en;
  logic                       inhibit;
  logic [4*PLAYERS-1:0]       dir_a, dir_b;
  logic [BUTTONS*PLAYERS-1:0] btn_a, btn_b;
  logic [PLAYERS-1:0]         start_a, start_b;
  logic [PLAYERS-1:0]         coin_a, coin_b;

  exp_t sb[$];
  int   cyc      = 0;
  int   chk_cnt  = 0;
  int   fail_cnt = 0;
  logic tog;

  input_mapper #(
    .PLAYERS(PLAYERS), .BUTTONS(BUTTONS), .SOCD_NEUTRAL(1),
    .COIN_CYCLES(5), .AUTOFIRE_DIV(3)
  ) dut_a (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
    .autofire_en(autofire_en), .inhibit(inhibit),
    .dir(dir_a), .buttons(btn_a), .start(start_a), .coin(coin_a)
  );

  input_mapper #(
    .PLAYERS(PLAYERS), .BUTTONS(BUTTONS), .SOCD_NEUTRAL(0),
    .COIN_CYCLES(5), .AUTOFIRE_DIV(3)
  ) dut_b (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
    .autofire_en(autofire_en), .inhibit(inhibit),
    .dir(dir_b), .buttons(btn_b), .start(start_b), .coin(coin_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due this cycle, flag stale ones.
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        case (sb[i].sig)
          S_DIR:   act = 32'(dir_a);
          S_BTN:   act = 32'(btn_a);
          S_START: act = 32'(start_a);
          S_COIN:  act = 32'(coin_a);
          default: act = 32'(dir_b);
        endcase
        chk_cnt++;
        if (sb[i].cyc < cyc) begin
          fail_cnt++;
          $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", sb[i].name, sb[i].cyc, cyc);
        end else if (act !== sb[i].val) begin
          fail_cnt++;
          $display("FAIL %s @cycle %0d: got %0h, expected %0h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic exp_at(input int d, input string nm, input int sig, input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc + d;
    e.name = nm;
    e.sig  = sig;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic pressed, input logic [7:0] code);
    tog     = ~tog;
    ps2_key = {tog, pressed, 1'b0, code};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with live-looking inputs: outputs must stay 0.
    reset       = 1'b1;
    inhibit     = 1'b0;
    autofire_en = '0;
    joystick    = 16'h0041;
    tog         = 1'b1;
    ps2_key     = {1'b1, 1'b1, 1'b0, 8'h6B};
    tick(2);
    exp_at(0, "rst_dir",   S_DIR,   0);
    exp_at(0, "rst_start", S_START, 0);
    exp_at(1, "rst_btn",   S_BTN,   0);
    tick(2);

    // Release; static toggle=1 must not be decoded as a left-arrow make.
    reset    = 1'b0;
    joystick = '0;
    for (int d = 1; d <= 4; d++) exp_at(d, "prime_dir", S_DIR, 0);
    tick(4);

    // Keyboard left: make then break, two-edge latency.
    send_key(1'b1, 8'h6B);
    exp_at(1, "kbd_left_lat", S_DIR, 8'h00);
    exp_at(2, "kbd_left_on",  S_DIR, 8'h02);
    tick(4);
    send_key(1'b0, 8'h6B);
    exp_at(1, "kbd_left_hold", S_DIR, 8'h02);
    exp_at(2, "kbd_left_off",  S_DIR, 8'h00);
    tick(3);

    // SOCD cleaning, joystick path, one-cycle latency.
    joystick = 16'h0003;
    exp_at(1, "socd_lr",    S_DIR,   8'h00);
    exp_at(1, "nosocd_lr",  S_DIR_B, 8'h03);
    tick(2);
    joystick = 16'h0002;
    exp_at(1, "socd_left",  S_DIR,   8'h02);
    tick(2);
    joystick = 16'h0C0F;
    exp_at(1, "socd_both",  S_DIR,   8'h00);
    exp_at(1, "nosocd_both", S_DIR_B, 8'hCF);
    tick(2);
    joystick = '0;
    tick(2);

    // Coin key held 20 cycles: one 5-cycle pulse; joystick re-press ignored.
    send_key(1'b1, 8'h2E);
    for (int d = 1; d <= 22; d++) exp_at(d, "coin_key", S_COIN, (d >= 2 && d <= 6) ? 1 : 0);
    tick(3);
    joystick = 16'h0080;
    tick(2);
    joystick = '0;
    tick(15);
    send_key(1'b0, 8'h2E);
    tick(3);
    joystick = 16'h0080;
    for (int d = 1; d <= 8; d++) exp_at(d, "coin_joy", S_COIN, (d <= 5) ? 1 : 0);
    tick(10);
    joystick = '0;
    tick(2);

    // Autofire on player 1 (key 1C), 3-cycle half period.
    autofire_en = 2'b10;
    send_key(1'b1, 8'h1C);
    for (int d = 1; d <= 17; d++)
      exp_at(d, "af_pattern", S_BTN, (d >= 2 && d <= 15 && ((d - 2) / 3) % 2 == 0) ? 4'h4 : 4'h0);
    tick(14);
    send_key(1'b0, 8'h1C);
    tick(5);

    // Autofire disabled: button passes through steady.
    autofire_en = 2'b00;
    send_key(1'b1, 8'h1C);
    exp_at(1, "af_off_lat", S_BTN, 4'h0);
    for (int d = 2; d <= 6; d++) exp_at(d, "af_off_steady", S_BTN, 4'h4);
    tick(6);
    // Enable rising while held: fire starts with phase 1 next cycle.
    autofire_en = 2'b10;
    for (int d = 1; d <= 8; d++)
      exp_at(d, "af_en_rise", S_BTN, (((d - 1) / 3) % 2 == 0) ? 4'h4 : 4'h0);
    tick(7);
    send_key(1'b0, 8'h1C);
    exp_at(2, "af_release", S_BTN, 4'h0);
    tick(3);
    autofire_en = 2'b00;

    // Inhibit with key 14 held and a coin pulse running.
    send_key(1'b1, 8'h14);
    exp_at(1, "btn0_lat", S_BTN, 4'h0);
    exp_at(2, "btn0_on",  S_BTN, 4'h1);
    tick(3);
    joystick = 16'h0080;
    exp_at(1, "coin_pre_inh", S_COIN, 1);
    exp_at(2, "coin_pre_inh", S_COIN, 1);
    tick(2);
    inhibit = 1'b1;
    for (int d = 1; d <= 3; d++) begin
      exp_at(d, "inh_btn",  S_BTN,  0);
      exp_at(d, "inh_coin", S_COIN, 0);
      exp_at(d, "inh_dir",  S_DIR,  0);
    end
    tick(1);
    send_key(1'b1, 8'h6B);
    tick(2);
    inhibit = 1'b0;
    for (int d = 1; d <= 7; d++) begin
      exp_at(d, "post_inh_coin", S_COIN, (d <= 5) ? 1 : 0);
      exp_at(d, "post_inh_btn",  S_BTN,  0);
      exp_at(d, "post_inh_dir",  S_DIR,  0);
    end
    tick(8);
    joystick = '0;
    send_key(1'b1, 8'h14);
    exp_at(1, "btn0_remake_lat", S_BTN, 4'h0);
    exp_at(2, "btn0_remake",     S_BTN, 4'h1);
    tick(3);

    // Start passes straight through, one cycle.
    send_key(1'b0, 8'h14);
    joystick = 16'h4000;
    exp_at(1, "start_p1",  S_START, 2'b10);
    exp_at(2, "btn0_brk",  S_BTN,   4'h0);
    tick(3);
    joystick = '0;
    exp_at(1, "start_off", S_START, 2'b00);
    tick(3);

    // Reset in mid-pulse clears coin at once and nothing resumes.
    joystick = 16'h0080;
    exp_at(1, "coin_pre_rst", S_COIN, 1);
    tick(2);
    reset = 1'b1;
    exp_at(0, "coin_rst_now",  S_COIN, 0);
    exp_at(1, "coin_rst_held", S_COIN, 0);
    tick(2);
    joystick = '0;
    tick(1);
    reset = 1'b0;
    for (int d = 1; d <= 3; d++) exp_at(d, "coin_after_rst", S_COIN, 0);
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/input_mapper.md
Name: input_mapper

Overview:
- Parametrised player-input front end between hps_io (ps2_key, joystick_N) and the game core.
- Decodes PS/2 make/break events into per-key state for players 0 and 1, ORs them with up to PLAYERS joystick words, and applies opposing-direction cleaning, per-player autofire, coin pulse shaping and an inhibit (download) gate.
- All outputs are registered and feed the game's joystick/start/coin inputs directly.

Parameters:
- PLAYERS, 2, number of players (1..4); keyboard drives players 0 and 1 only.
- BUTTONS, 2, action buttons per player (1..4).
- SOCD_NEUTRAL, 1, 1: left+right → neither and up+down → neither; 0: pass through.
- COIN_CYCLES, 96000, coin output pulse length in clk cycles (≥1).
- AUTOFIRE_DIV, 800000, clk cycles per autofire half-period (≥1).
- JOY_W, 6+BUTTONS, derived (localparam): joystick word width.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-high.
- ps2_key, in, 11, [10] toggle per event, [9] pressed, [8] extended (ignored), [7:0] scan code.
- joystick, in, PLAYERS*JOY_W, player p at [p*JOY_W +: JOY_W]; bit 0 right, 1 left, 2 down, 3 up, 4..3+BUTTONS buttons, 4+BUTTONS start, 5+BUTTONS coin.
- autofire_en, in, PLAYERS, per-player autofire enable for button 0.
- inhibit, in, 1, forces all outputs low and clears keyboard/coin/autofire state.
- dir, out, 4*PLAYERS, player p at [4p +: 4], order {up,down,left,right}.
- buttons, out, BUTTONS*PLAYERS, player p at [p*BUTTONS +: BUTTONS].
- start, out, PLAYERS.
- coin, out, PLAYERS.

Behaviour:
- Reset: all outputs 0. Key state, coin counters and autofire counters/phases 0. primed = 0.
- Key event detection: old_toggle is registered every cycle. The first cycle after reset release only captures ps2_key[10] (primed ← 1) and decodes nothing. After that, ps2_key[10] ≠ old_toggle is one event. key_state[code] ← ps2_key[9].
- Key map, player 0: up 75, down 72, left 6B, right 74, btn0 14, btn1 11, btn2 29, btn3 12, start 16, coin 2E.
- Key map, player 1: up 2D, down 2B, left 23, right 34, btn0 1C, btn1 1B, btn2 15, btn3 1D, start 1E, coin 36.
- Codes for buttons ≥ BUTTONS, and all unlisted codes, are ignored.
- Raw per player = joystick word OR key_state (keyboard contributes only for p<2).
- Latency: joystick to output is 1 cycle. Key event sampled at edge k updates key_state at edge k; the output updates at edge k+1.
- SOCD (SOCD_NEUTRAL=1): if raw left and raw right are both set, both outputs are 0. Same rule for up/down. Evaluated per player, combinationally before the output register.
- Autofire, per player, when autofire_en[p]=1:
  - States IDLE / FIRE.
  - IDLE→FIRE on raw btn0 rising (prev-sample register): phase←1, cnt←0.
  - In FIRE: cnt increments; at cnt=AUTOFIRE_DIV-1, cnt←0 and phase toggles. buttons[p*BUTTONS] = phase.
  - FIRE→IDLE when raw btn0=0: phase←0, cnt←0 the same cycle.
  - autofire_en low → btn0 passes through; FIRE→IDLE immediately.
  - autofire_en rising while btn0 held → enter FIRE with phase=1 next cycle.
- Coin, per player:
  - States IDLE / PULSE.
  - Raw coin rising edge in IDLE → PULSE, cnt←COIN_CYCLES-1, coin=1.
  - In PULSE: decrement each cycle; cnt=0 → IDLE. The output is high for exactly COIN_CYCLES cycles.
  - Rising edges during PULSE are ignored.
  - Coin held continuously gives one pulse; a new pulse needs a release then a press.
  - Simultaneous keyboard and joystick coin is one pulse (OR before edge detect).
- Inhibit=1:
  - Next edge: all outputs 0.
  - key_state, coin FSM and autofire FSM cleared; old_toggle still tracks ps2_key[10].
  - Events arriving during inhibit are discarded.
  - On inhibit falling, a coin or btn0 held at that moment counts as a new rising edge on the next cycle.
- Reset mid-pulse or mid-autofire: asynchronous clear to reset values; no partial pulse resumes.
- Start: raw OR, registered, no shaping.

Test Plan:
- Reset then ps2_key[10]=1 static → no key_state change; dir[3:0]=0 throughout.
- Toggle ps2_key with {pressed=1, code=6B} → dir[1]=1 two edges after sampling. Toggle with {pressed=0, 6B} → dir[1]=0 two edges later.
- SOCD_NEUTRAL=1: joystick p0 = 0x03 (L+R) → dir[1:0]=00. Drop right → dir[1:0]=10 (left) after 1 cycle. SOCD_NEUTRAL=0 → 11.
- COIN_CYCLES=5: press key 2E for 20 cycles → coin[0] high exactly 5 cycles. Re-press joystick coin at cycle 3 → no extension. Release/press → second 5-cycle pulse.
- AUTOFIRE_DIV=3, autofire_en[1]=1, hold key 1C for 14 cycles → buttons[BUTTONS] pattern 111000111000…; release → 0 the next cycle. autofire_en=0 → held steady high.
- Assert inhibit while key 14 held and coin pulse active → all outputs 0 next edge. Deassert inhibit with joystick coin held → one fresh COIN_CYCLES pulse; key 14 remains 0 until a new make event.
